// File: rtl/stage3_frame_ctrl.sv
// Frame sequencer ahead of stage-3 CNN: forwards one frame of ReLU beats, then holds one ASCII result.
// Optional result-wait timeout enabled by defining STAGE3_FRAME_CTRL_TIMEOUT_EN. DATA_W mirrors CI*IF_BW.
module stage3_frame_ctrl #(
  parameter int DATA_W          = 32,
  parameter int BEATS_PER_FRAME = 36,
  parameter int CNT_W           = 6,
  parameter int TIMEOUT_CYC     = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  output logic              o_busy,
  input  logic              i_relu_valid,
  input  logic [DATA_W-1:0] i_relu_data,
  output logic              o_relu_valid,
  output logic [DATA_W-1:0] o_relu_data,
  input  logic              i_res_valid,
  input  logic [7:0]        i_res_alpha,
  output logic              o_char_valid,
  input  logic              i_char_ready,
  output logic [7:0]        o_char,
  output logic              o_frame_done,
  output logic              o_drop,
`ifdef STAGE3_FRAME_CTRL_TIMEOUT_EN
  output logic              o_timeout,
`endif
  output logic [1:0]        o_state
);

  // Character handshake: o_char transfers on any cycle where o_char_valid && i_char_ready;
  // o_char_valid never drops and o_char never changes until that transfer happens.

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, WAIT_RES = 2'd2, HOLD = 2'd3} state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_FRAME - 1);

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;

`ifdef STAGE3_FRAME_CTRL_TIMEOUT_EN
  localparam int               WAIT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  logic [WAIT_W-1:0] wait_cnt;
`endif

  assign o_state = state;
  assign o_busy  = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      o_relu_valid <= 1'b0;
      o_relu_data  <= '0;
      o_char_valid <= 1'b0;
      o_char       <= 8'h00;
      o_frame_done <= 1'b0;
      o_drop       <= 1'b0;
`ifdef STAGE3_FRAME_CTRL_TIMEOUT_EN
      wait_cnt     <= '0;
      o_timeout    <= 1'b0;
`endif
    end else begin
      o_relu_valid <= 1'b0;
      o_frame_done <= 1'b0;
      o_drop       <= 1'b0;
`ifdef STAGE3_FRAME_CTRL_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
      case (state)
        IDLE: begin
          // A beat coinciding with i_start is still outside the frame and is dropped.
          if (i_relu_valid || i_res_valid) o_drop <= 1'b1;
          if (i_start) begin
            state    <= STREAM;
            beat_cnt <= '0;
          end
        end
        STREAM: begin
          if (i_res_valid) o_drop <= 1'b1;
          if (i_relu_valid) begin
            o_relu_valid <= 1'b1;
            o_relu_data  <= i_relu_data;
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= WAIT_RES;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        WAIT_RES: begin
          if (i_relu_valid) o_drop <= 1'b1;
          if (i_res_valid) begin
            o_char       <= i_res_alpha;
            o_char_valid <= 1'b1;
            state        <= HOLD;
          end
`ifdef STAGE3_FRAME_CTRL_TIMEOUT_EN
          // Real result takes priority over a timeout landing in the same cycle.
          else if (wait_cnt == WAIT_LAST) begin
            o_char       <= 8'h3F;
            o_char_valid <= 1'b1;
            o_timeout    <= 1'b1;
            state        <= HOLD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (i_relu_valid || i_res_valid) o_drop <= 1'b1;
          if (i_char_ready) begin
            o_char_valid <= 1'b0;
            o_frame_done <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stage3_frame_ctrl.md
Name: stage3_frame_ctrl

Overview:
- Frame sequencer in front of the stage-3 CNN (max-pool, channel accumulate, core, argmax-to-ASCII).
- Opens a frame on a start pulse and forwards exactly BEATS_PER_FRAME ReLU beats into stage 3.
- Waits for the single classification result, then holds the ASCII character for a downstream braille/UART consumer under a valid/ready handshake.
- Guarantees one character per frame and keeps stray beats from corrupting the stage-3 pooling and accumulator state.

Parameters:
- DATA_W, `CI*`IF_BW: width of one ReLU beat, taken from stage3_defines_cnn_core.vh.
- BEATS_PER_FRAME, 36: ReLU beats per frame (≥2).
- CNT_W, 6: beat counter width; must satisfy 2^CNT_W > BEATS_PER_FRAME.
- TIMEOUT_CYC, 256: result wait limit in cycles. Used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_start  in  1  frame start pulse.
- o_busy  out  1  high whenever state != IDLE.
- i_relu_valid  in  1  upstream ReLU beat valid.
- i_relu_data  in  DATA_W  upstream ReLU beat.
- o_relu_valid  out  1  to stage-3 i_Relu_valid.
- o_relu_data  out  DATA_W  to stage-3 i_in_Relu.
- i_res_valid  in  1  from stage-3 o_valid.
- i_res_alpha  in  8  from stage-3 alpha.
- o_char_valid  out  1  character valid.
- i_char_ready  in  1  consumer ready.
- o_char  out  8  ASCII result.
- o_frame_done  out  1  one-cycle pulse on character handshake.
- o_drop  out  1  one-cycle pulse when a beat or result is discarded.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, beat counter=0, all outputs 0, o_char=8'h00.
- FSM states: IDLE, STREAM, WAIT_RES, HOLD.
- IDLE:
  - i_start=1 -> STREAM, counter cleared.
  - i_relu_valid=1 -> beat discarded, o_drop pulse.
  - i_res_valid=1 -> ignored, o_drop pulse.
  - A beat arriving in the same cycle as i_start is discarded; forwarding begins the cycle after.
- STREAM:
  - Each i_relu_valid beat is registered to o_relu_valid/o_relu_data with exactly 1 cycle latency, and the counter increments.
  - On the beat where counter==BEATS_PER_FRAME-1 -> WAIT_RES, counter cleared.
  - o_relu_valid is 0 in every cycle without an accepted beat; o_relu_data holds its last value.
  - i_res_valid in STREAM: ignored, o_drop pulse.
  - i_start ignored in all states except IDLE.
- WAIT_RES:
  - i_relu_valid beats are discarded with an o_drop pulse; none reach stage 3.
  - i_res_valid=1 -> i_res_alpha captured into o_char, o_char_valid=1 next cycle, state -> HOLD.
- HOLD:
  - o_char_valid stays 1 and o_char stays stable until i_char_ready=1.
  - On the handshake cycle: o_char_valid->0 and o_frame_done pulses on the next edge, state -> IDLE.
  - i_char_ready while o_char_valid=0 has no effect.
  - A further i_res_valid in HOLD is discarded with an o_drop pulse; the held character is not overwritten.
- o_drop fires at most once per cycle even if a beat and a result are discarded together.
- Back-to-back frames: i_start may be asserted in the cycle after o_frame_done.
- Reset asserted mid-frame aborts it: no character is emitted, and downstream stage 3 must also be reset by the same system reset.

Optional Feature:
- Macro: STAGE3_FRAME_CTRL_TIMEOUT_EN.
- Defined:
  - A wait counter runs in WAIT_RES.
  - If TIMEOUT_CYC cycles elapse with no i_res_valid, o_char=8'h3F ('?') and o_char_valid=1, then go to HOLD.
  - The sticky output o_timeout (extra port, 1 bit, reset 0) is set; it clears only on reset.
  - If a result and the timeout coincide in the same cycle, the result wins.
- Not defined: WAIT_RES waits indefinitely, and neither the counter nor o_timeout exists.

Test Plan:
- Nominal frame: i_start, then 36 beats with data 0..35 -> o_relu_valid mirrors each beat 1 cycle later with the same data. i_res_valid with alpha 8'h62 -> o_char=8'h62, o_char_valid=1. With i_char_ready=1 -> o_frame_done pulses once, o_busy=0.
- Gapped input: 36 beats with random 0-3 cycle bubbles -> exactly 36 o_relu_valid pulses, and the state enters WAIT_RES only after the 36th.
- Stray traffic: beats in IDLE, a 37th beat in WAIT_RES, and i_res_valid during STREAM -> each gives an o_drop pulse, zero extra o_relu_valid, and o_char unchanged.
- Backpressure: result 8'h63 with i_char_ready low for 10 cycles -> o_char_valid and o_char stable throughout; a second i_res_valid (8'h61) in HOLD -> o_drop pulses and o_char stays 8'h63.
- Reset mid-STREAM after beat 20 -> outputs 0 immediately, state IDLE. A fresh frame then needs all 36 beats.
- Timeout (macro defined): no result for 256 cycles -> o_char=8'h3F and o_timeout=1. Result arriving on cycle 256 -> real alpha is emitted and o_timeout stays 0.
